// File: rtl/gemm_ws_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : gemm_ws_stream_if
// Purpose  : Bundles the weight-load, activation-in and result-out streams of
//            the weight-stationary GEMM engine.
// Signals  : wgt_valid/wgt_ready/wgt_row   - weight row beats (row k of W)
//            in_valid/in_ready/in_vec      - activation vectors a[0..N-1]
//            out_valid/out_ready/out_vec   - result vectors out[0..N-1]
//            weights_loaded                - active bank holds a full matrix
//            inflight                      - vectors accepted, not delivered
// Modports : master drives the streams (traffic source / sink),
//            slave is the engine.
// Revision : 1.0 - initial release
// ============================================================================
interface gemm_ws_stream_if #(
    parameter int SA_SIZE   = 4,
    parameter int ACT_WIDTH = 8,
    parameter int WGT_WIDTH = 8,
    parameter int ACC_WIDTH = 32
);
    localparam int c_cnt_w = $clog2(2*SA_SIZE+1);

    logic                           wgt_valid;
    logic                           wgt_ready;
    logic [SA_SIZE*WGT_WIDTH-1:0]   wgt_row;
    logic                           in_valid;
    logic                           in_ready;
    logic [SA_SIZE*ACT_WIDTH-1:0]   in_vec;
    logic                           out_valid;
    logic                           out_ready;
    logic [SA_SIZE*ACC_WIDTH-1:0]   out_vec;
    logic                           weights_loaded;
    logic [c_cnt_w-1:0]             inflight;

    modport master (
        output wgt_valid, wgt_row, in_valid, in_vec, out_ready,
        input  wgt_ready, in_ready, out_valid, out_vec, weights_loaded, inflight
    );

    modport slave (
        input  wgt_valid, wgt_row, in_valid, in_vec, out_ready,
        output wgt_ready, in_ready, out_valid, out_vec, weights_loaded, inflight
    );
endinterface
`default_nettype wire

// File: rtl/gemm_ws_stream.sv
`default_nettype none
// ============================================================================
// Module   : gemm_ws_stream
// Purpose  : Weight-stationary streaming matrix-vector engine.
//            out[i] = sum_j a[j] * W[j][i]  (mod 2^ACC_WIDTH).
//            Weights are double-buffered: rows stream into a shadow bank and
//            are swapped into the active bank only when the pipeline is empty.
// Ports    : clk            - rising-edge clock
//            resetn         - synchronous active-low reset
//            bus (slave)    - weight / activation / result streams and status
// Revision : 1.0 - initial release
// ============================================================================
module gemm_ws_stream #(
    parameter int SA_SIZE   = 4,
    parameter int ACT_WIDTH = 8,
    parameter int WGT_WIDTH = 8,
    parameter int ACC_WIDTH = 32,
    parameter int SIGNED    = 0
) (
    input  logic                clk,
    input  logic                resetn,
    gemm_ws_stream_if.slave     bus
);
    localparam int c_depth = 2*SA_SIZE;
    localparam int c_cnt_w = $clog2(2*SA_SIZE+1);
    localparam int c_row_w = $clog2(SA_SIZE);

    typedef logic [ACC_WIDTH-1:0] acc_t;

    // Extend both operands to the accumulator width, then multiply; the
    // truncated product is exact modulo 2^ACC_WIDTH for either signedness.
    function automatic acc_t mul(input logic [ACT_WIDTH-1:0] a,
                                 input logic [WGT_WIDTH-1:0] w);
        acc_t ax;
        acc_t wx;
        if (SIGNED != 0) begin
            ax = {{(ACC_WIDTH-ACT_WIDTH){a[ACT_WIDTH-1]}}, a};
            wx = {{(ACC_WIDTH-WGT_WIDTH){w[WGT_WIDTH-1]}}, w};
        end else begin
            ax = {{(ACC_WIDTH-ACT_WIDTH){1'b0}}, a};
            wx = {{(ACC_WIDTH-WGT_WIDTH){1'b0}}, w};
        end
        return ax * wx;
    endfunction

    logic [WGT_WIDTH-1:0]   shadow_q [SA_SIZE][SA_SIZE];
    logic [WGT_WIDTH-1:0]   active_q [SA_SIZE][SA_SIZE];
    logic [c_row_w-1:0]     row_q;
    logic                   shadow_full_q;
    logic                   weights_loaded_q;
    logic [c_cnt_w-1:0]     inflight_q;
    logic [c_depth-1:0]     vld_q;
    // Activation vector travelling alongside the compute stages; stage s only
    // consumes element s, which gives activation row j its j-cycle skew.
    logic [ACT_WIDTH-1:0]   act_q  [SA_SIZE-1][SA_SIZE];
    acc_t                   psum_q [c_depth][SA_SIZE];
    acc_t                   psum_d [c_depth][SA_SIZE];

    logic [ACT_WIDTH-1:0]   w_in_act  [SA_SIZE];
    logic [WGT_WIDTH-1:0]   w_wgt_row [SA_SIZE];
    logic                   w_stall;
    logic                   w_en;
    logic                   w_swap_pending;
    logic                   w_swap;
    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_deliver;
    logic                   w_wgt_accept;

    always_comb begin
        for (int j = 0; j < SA_SIZE; j++) begin
            w_in_act[j]  = bus.in_vec[j*ACT_WIDTH +: ACT_WIDTH];
            w_wgt_row[j] = bus.wgt_row[j*WGT_WIDTH +: WGT_WIDTH];
        end
        w_stall        = vld_q[c_depth-1] && !bus.out_ready;
        w_en           = !w_stall;
        w_swap_pending = shadow_full_q && (inflight_q != '0);
        w_swap         = shadow_full_q && (inflight_q == '0);
        // Holding input while a full shadow bank waits guarantees that every
        // vector in the pipe was computed with one matrix only.
        w_in_ready     = weights_loaded_q && !w_swap_pending && !w_stall && !shadow_full_q;
        w_accept       = bus.in_valid && w_in_ready;
        w_deliver      = vld_q[c_depth-1] && bus.out_ready;
        w_wgt_accept   = bus.wgt_valid && !shadow_full_q;
    end

    // Stage 0 applies row 0, stage s applies row s to the running sum; the
    // remaining SA_SIZE stages re-align results so all lanes leave together.
    always_comb begin
        for (int i = 0; i < SA_SIZE; i++) begin
            psum_d[0][i] = mul(w_in_act[0], active_q[0][i]);
        end
        for (int s = 1; s < SA_SIZE; s++) begin
            for (int i = 0; i < SA_SIZE; i++) begin
                psum_d[s][i] = psum_q[s-1][i] + mul(act_q[s-1][s], active_q[s][i]);
            end
        end
        for (int s = SA_SIZE; s < c_depth; s++) begin
            for (int i = 0; i < SA_SIZE; i++) begin
                psum_d[s][i] = psum_q[s-1][i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_q            <= '0;
            row_q            <= '0;
            shadow_full_q    <= 1'b0;
            weights_loaded_q <= 1'b0;
            inflight_q       <= '0;
            for (int s = 0; s < c_depth; s++) begin
                for (int i = 0; i < SA_SIZE; i++) begin
                    psum_q[s][i] <= '0;
                end
            end
            for (int s = 0; s < SA_SIZE-1; s++) begin
                for (int j = 0; j < SA_SIZE; j++) begin
                    act_q[s][j] <= '0;
                end
            end
            for (int k = 0; k < SA_SIZE; k++) begin
                for (int i = 0; i < SA_SIZE; i++) begin
                    shadow_q[k][i] <= '0;
                    active_q[k][i] <= '0;
                end
            end
        end else begin
            if (w_en) begin
                vld_q    <= {vld_q[c_depth-2:0], w_accept};
                psum_q   <= psum_d;
                act_q[0] <= w_in_act;
                for (int s = 1; s < SA_SIZE-1; s++) begin
                    act_q[s] <= act_q[s-1];
                end
            end

            // Beat acceptance needs !shadow_full and swap needs shadow_full,
            // so the two branches never fire together.
            if (w_wgt_accept) begin
                shadow_q[row_q] <= w_wgt_row;
                if (row_q == c_row_w'(SA_SIZE-1)) begin
                    row_q         <= '0;
                    shadow_full_q <= 1'b1;
                end else begin
                    row_q <= row_q + c_row_w'(1);
                end
            end
            if (w_swap) begin
                active_q         <= shadow_q;
                shadow_full_q    <= 1'b0;
                weights_loaded_q <= 1'b1;
            end

            case ({w_accept, w_deliver})
                2'b10:   inflight_q <= inflight_q + c_cnt_w'(1);
                2'b01:   inflight_q <= inflight_q - c_cnt_w'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    always_comb begin
        bus.out_vec = '0;
        for (int i = 0; i < SA_SIZE; i++) begin
            bus.out_vec[i*ACC_WIDTH +: ACC_WIDTH] = psum_q[c_depth-1][i];
        end
    end

    assign bus.wgt_ready      = !shadow_full_q;
    assign bus.in_ready       = w_in_ready;
    assign bus.out_valid      = vld_q[c_depth-1];
    assign bus.weights_loaded = weights_loaded_q;
    assign bus.inflight       = inflight_q;

endmodule
`default_nettype wire

// File: tb/tb_gemm_ws_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_gemm_ws_stream
// Purpose  : Self-checking bench for gemm_ws_stream. An unsigned and a signed
//            instance (SA_SIZE=2, 8-bit operands, 32-bit results) receive the
//            same streams; a queue-based model predicts every output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gemm_ws_stream;
    localparam int N   = 2;
    localparam int LAT = 2*N;

    logic        clk;
    logic        resetn;
    logic        wgt_valid;
    logic [15:0] wgt_row;
    logic        in_valid;
    logic [15:0] in_vec;
    logic        out_ready;

    gemm_ws_stream_if #(.SA_SIZE(N), .ACT_WIDTH(8), .WGT_WIDTH(8), .ACC_WIDTH(32)) bu ();
    gemm_ws_stream_if #(.SA_SIZE(N), .ACT_WIDTH(8), .WGT_WIDTH(8), .ACC_WIDTH(32)) bs ();

    assign bu.wgt_valid = wgt_valid;
    assign bu.wgt_row   = wgt_row;
    assign bu.in_valid  = in_valid;
    assign bu.in_vec    = in_vec;
    assign bu.out_ready = out_ready;
    assign bs.wgt_valid = wgt_valid;
    assign bs.wgt_row   = wgt_row;
    assign bs.in_valid  = in_valid;
    assign bs.in_vec    = in_vec;
    assign bs.out_ready = out_ready;

    gemm_ws_stream #(.SA_SIZE(N), .ACT_WIDTH(8), .WGT_WIDTH(8), .ACC_WIDTH(32), .SIGNED(0))
        u_dut_u (.clk(clk), .resetn(resetn), .bus(bu.slave));
    gemm_ws_stream #(.SA_SIZE(N), .ACT_WIDTH(8), .WGT_WIDTH(8), .ACC_WIDTH(32), .SIGNED(1))
        u_dut_s (.clk(clk), .resetn(resetn), .bus(bs.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [15:0] a;
        logic [31:0] w;     // row k at [k*16 +: 16], element i of a row at [i*8 +: 8]
        int          age;   // enabled clock edges since acceptance
    } ent_t;
    typedef struct {
        logic [31:0] u0, u1, s0, s1;
        int          cyc;
    } dlv_t;

    ent_t        q[$];
    dlv_t        dlog[$];
    logic [31:0] m_shadow = '0;
    logic [31:0] m_cur    = '0;
    int          m_row    = 0;
    bit          m_pending = 0;
    bit          m_loaded  = 0;
    bit          mon_on    = 0;
    int          max_infl  = 0;
    int          ov_cnt    = 0;

    function automatic logic [31:0] exp_out(input logic [15:0] a, input logic [31:0] w,
                                            input int i, input bit sgn);
        longint sum;
        longint av;
        longint wv;
        logic [7:0] ae;
        logic [7:0] we;
        sum = 0;
        for (int j = 0; j < N; j++) begin
            ae = a[j*8 +: 8];
            we = w[j*16 + i*8 +: 8];
            av = sgn ? longint'($signed(ae)) : longint'(ae);
            wv = sgn ? longint'($signed(we)) : longint'(we);
            sum += av * wv;
        end
        return sum[31:0];
    endfunction

    int   n0;
    bit   eov, estall, eir, swap_now, wacc;
    ent_t ne;
    dlv_t nd;

    always @(negedge clk) begin
        if (mon_on) begin
            n0  = q.size();
            eov = (n0 > 0) && (q[0].age >= LAT);
            chk("out_valid_u", bu.out_valid, eov);
            chk("out_valid_s", bs.out_valid, eov);
            if (eov) begin
                for (int i = 0; i < N; i++) begin
                    chk("out_vec_u", bu.out_vec[i*32 +: 32], exp_out(q[0].a, q[0].w, i, 1'b0));
                    chk("out_vec_s", bs.out_vec[i*32 +: 32], exp_out(q[0].a, q[0].w, i, 1'b1));
                end
            end
            chk("inflight_u", bu.inflight, n0);
            chk("inflight_s", bs.inflight, n0);
            estall = eov && !out_ready;
            eir    = m_loaded && !m_pending && !estall;
            chk("in_ready_u", bu.in_ready, eir);
            chk("in_ready_s", bs.in_ready, eir);
            chk("wgt_ready_u", bu.wgt_ready, !m_pending);
            chk("wgt_ready_s", bs.wgt_ready, !m_pending);
            chk("weights_loaded_u", bu.weights_loaded, m_loaded);
            chk("weights_loaded_s", bs.weights_loaded, m_loaded);
            if (n0 > max_infl) max_infl = n0;
            if (bu.out_valid) ov_cnt++;

            if (!resetn) begin
                q.delete();
                m_row     = 0;
                m_pending = 0;
                m_loaded  = 0;
                m_shadow  = '0;
            end else begin
                swap_now = m_pending && (n0 == 0);
                wacc     = wgt_valid && !m_pending;
                if (eov && out_ready) begin
                    nd.u0  = bu.out_vec[31:0];
                    nd.u1  = bu.out_vec[63:32];
                    nd.s0  = bs.out_vec[31:0];
                    nd.s1  = bs.out_vec[63:32];
                    nd.cyc = cyc;
                    dlog.push_back(nd);
                    void'(q.pop_front());
                end
                if (in_valid && eir) begin
                    ne.a   = in_vec;
                    ne.w   = m_cur;
                    ne.age = 0;
                    q.push_back(ne);
                end
                if (swap_now) begin
                    m_pending = 0;
                    m_loaded  = 1;
                end
                if (wacc) begin
                    m_shadow[m_row*16 +: 16] = wgt_row;
                    if (m_row == N-1) begin
                        m_row     = 0;
                        m_pending = 1;
                        m_cur     = m_shadow;
                    end else begin
                        m_row++;
                    end
                end
                if (!estall) begin
                    foreach (q[k]) q[k].age++;
                end
            end
        end
    end

    // ---------------- stimulus helpers (all return at posedge + 1) ----------------
    task automatic load_row(input logic [15:0] r);
        bit rdy;
        bit done;
        done      = 0;
        wgt_valid = 1'b1;
        wgt_row   = r;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk); rdy = bu.wgt_ready;
            @(posedge clk); #1;
            done = rdy;
        end
        wgt_valid = 1'b0;
        if (!done) chk("wgt_handshake_timeout", 1, 0);
    endtask

    task automatic send_vec(input logic [15:0] v, output int acyc);
        bit rdy;
        bit done;
        done     = 0;
        acyc     = -1;
        in_valid = 1'b1;
        in_vec   = v;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk); rdy = bu.in_ready; acyc = cyc;
            @(posedge clk); #1;
            done = rdy;
        end
        in_valid = 1'b0;
        if (!done) chk("in_handshake_timeout", 1, 0);
    endtask

    task automatic wait_dlog(input int n);
        bit done;
        done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            done = (dlog.size() >= n);
        end
        @(posedge clk); #1;
        if (!done) chk("result_timeout", dlog.size(), n);
    endtask

    task automatic wait_swap();
        bit done;
        done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            done = bu.wgt_ready && bu.weights_loaded;
        end
        @(posedge clk); #1;
        if (!done) chk("swap_timeout", 1, 0);
    endtask

    task automatic chk_dlv(input string nm, input int idx, input logic [31:0] e0, input logic [31:0] e1);
        if (idx < dlog.size()) begin
            chk({nm, "_0"}, dlog[idx].u0, e0);
            chk({nm, "_1"}, dlog[idx].u1, e1);
        end else begin
            chk({nm, "_missing"}, dlog.size(), idx + 1);
        end
    endtask

    // ---------------- main sequence ----------------
    int ac;
    int ac2;
    int base;
    int ov0;

    initial begin
        resetn    = 1'b0;
        wgt_valid = 1'b0;
        wgt_row   = '0;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mon_on = 1;
        @(negedge clk);
        chk("rst_out_valid", bu.out_valid, 0);
        chk("rst_out_vec", bu.out_vec, 0);
        chk("rst_weights_loaded", bu.weights_loaded, 0);
        chk("rst_inflight", bu.inflight, 0);
        chk("rst_wgt_ready", bu.wgt_ready, 1);
        chk("rst_in_ready", bu.in_ready, 0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // W = [[3,0],[0,2]], a = [2,5] -> [6,10], 4 cycles after acceptance
        load_row({8'd0, 8'd3});
        load_row({8'd2, 8'd0});
        wait_swap();
        base = dlog.size();
        send_vec({8'd5, 8'd2}, ac);
        wait_dlog(base + 1);
        chk_dlv("single", base, 32'd6, 32'd10);
        if (base < dlog.size()) chk("latency", dlog[base].cyc - ac, LAT);

        // back-to-back
        base = dlog.size();
        send_vec({8'd5, 8'd2}, ac);
        send_vec({8'd2, 8'd3}, ac2);
        chk("b2b_accept_gap", ac2 - ac, 1);
        wait_dlog(base + 2);
        chk_dlv("b2b_first", base, 32'd6, 32'd10);
        chk_dlv("b2b_second", base + 1, 32'd9, 32'd4);
        if (base + 1 < dlog.size()) chk("b2b_out_gap", dlog[base+1].cyc - dlog[base].cyc, 1);

        // three-cycle output stall on the first result
        base      = dlog.size();
        out_ready = 1'b0;
        send_vec({8'd5, 8'd2}, ac);
        send_vec({8'd2, 8'd3}, ac2);
        begin
            bit seen;
            seen = 0;
            for (int k = 0; k < 50 && !seen; k++) begin
                @(negedge clk);
                seen = bu.out_valid;
            end
            if (!seen) chk("stall_out_timeout", 1, 0);
            chk("stall_hold_c1", bu.out_vec, {32'd10, 32'd6});
            @(negedge clk);
            chk("stall_hold_c2", bu.out_vec, {32'd10, 32'd6});
            @(negedge clk);
            chk("stall_hold_c3", bu.out_vec, {32'd10, 32'd6});
            @(posedge clk); #1;
            out_ready = 1'b1;
        end
        wait_dlog(base + 2);
        chk_dlv("stall_first", base, 32'd6, 32'd10);
        chk_dlv("stall_second", base + 1, 32'd9, 32'd4);
        chk("max_inflight_le_4", max_infl > 4, 0);

        // reload [[1,1],[1,1]] with two vectors in flight
        base = dlog.size();
        send_vec({8'd5, 8'd2}, ac);
        send_vec({8'd2, 8'd3}, ac);
        load_row({8'd1, 8'd1});
        load_row({8'd1, 8'd1});
        @(negedge clk);
        chk("swap_pending_in_ready", bu.in_ready, 0);
        chk("swap_pending_inflight", bu.inflight, 2);
        @(posedge clk); #1;
        wait_swap();
        send_vec({8'd5, 8'd2}, ac);
        // signed matrix W=[[-1,0],[0,-128]] queued while [2,5] is in flight
        load_row({8'h00, 8'hFF});
        load_row({8'h80, 8'h00});
        wait_swap();
        send_vec({8'h80, 8'h7F}, ac);
        wait_dlog(base + 4);
        chk_dlv("reload_old_first", base, 32'd6, 32'd10);
        chk_dlv("reload_old_second", base + 1, 32'd9, 32'd4);
        chk_dlv("reload_new", base + 2, 32'd7, 32'd7);
        chk_dlv("unsigned_view", base + 3, 32'd32385, 32'd16384);
        if (base + 3 < dlog.size()) begin
            chk("signed_out0", dlog[base+3].s0, 32'hFFFF_FF81);
            chk("signed_out1", dlog[base+3].s1, 32'd16384);
        end

        // reset with three vectors in flight and one shadow row loaded
        send_vec({8'd1, 8'd1}, ac);
        send_vec({8'd2, 8'd2}, ac);
        wgt_valid = 1'b1;
        wgt_row   = 16'h1234;
        send_vec({8'd3, 8'd3}, ac);
        wgt_valid = 1'b0;
        resetn    = 1'b0;
        @(negedge clk);
        chk("pre_reset_inflight", bu.inflight, 3);
        @(posedge clk); #1;
        resetn = 1'b1;
        ov0 = ov_cnt;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("post_reset_no_out", ov_cnt, ov0);
        chk("post_reset_weights_loaded", bu.weights_loaded, 0);
        chk("post_reset_wgt_ready", bu.wgt_ready, 1);
        chk("post_reset_inflight", bu.inflight, 0);
        @(posedge clk); #1;

        // randomized traffic, checked cycle by cycle by the model
        for (int c = 0; c < 600; c++) begin
            in_valid  = $urandom_range(0, 1) == 1;
            in_vec    = 16'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            wgt_valid = $urandom_range(0, 5) == 0;
            wgt_row   = 16'($urandom);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        wgt_valid = 1'b0;
        out_ready = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("drain_inflight", bu.inflight, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
